lift_seq: RTL and testbench
===========================

LIFT_SEQ -- requirements
Module: lift_seq

Interface
REQ-001 SHALL have parameter DW, default 11, meaning sample width of the add_mul inputs.
REQ-002 SHALL have parameter RW, default 36, meaning add_mul result width.
REQ-003 SHALL have parameter AW, default 9, meaning row memory address width.
REQ-004 SHALL have parameter LAT, default 1, meaning add_mul result latency in clocks after x1..x5 and odd_even are stable.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have the following row-control ports:
- start  in  1  one-cycle request to transform one row.
- row_len  in  AW  row length N, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on rejected row_len.
REQ-007 SHALL have the following row-memory ports:
- rd_en  out  1  memory read strobe.
- rd_addr  out  AW  read address.
- rd_data  in  DW  signed read data, valid exactly 1 clk after rd_en.
- wr_en  out  1  memory write strobe.
- wr_addr  out  AW  write address.
- wr_data  out  DW  signed write data.
REQ-008 SHALL have the following add_mul ports:
- x1..x5  out  DW each  signed window samples at index c-2..c+2.
- odd_even  out  1  1 = predict (odd center), 0 = update (even center).
- d3  in  RW  signed predict result.
- a2  in  RW  signed update result.

Function
REQ-009 SHALL implement states IDLE, LOAD, CAPT, WAIT, WRITE, NEXT, FIN.
REQ-010 In IDLE, start with 4 <= row_len <= 2^AW-1 SHALL latch N, set c=1, set odd_even=1, and go to LOAD.
REQ-011 In IDLE, start with row_len < 4 SHALL pulse err for one cycle, leave busy low, issue no memory access, and stay in IDLE.
REQ-012 start while busy SHALL be ignored.
REQ-013 LOAD SHALL assert rd_en for 5 consecutive cycles, for k=0..4, at address mirror(c-2+k).
- mirror(i) = -i when i<0.
- mirror(i) = 2(N-1)-i when i>N-1.
- mirror(i) = i otherwise.
REQ-014 Each rd_data word SHALL be captured into x(k+1) on the cycle after its read; the last capture occurs in CAPT.
REQ-015 x1..x5 and odd_even SHALL be held stable from the end of CAPT until WRITE completes.
REQ-016 WAIT SHALL last exactly LAT cycles; LAT=0 SHALL skip WAIT.
REQ-017 WRITE SHALL assert wr_en for one cycle with wr_addr=c.
- wr_data = sat(d3) when odd_even=1.
- wr_data = sat(a2) when odd_even=0.
- sat clamps the signed RW-bit value to [-2^(DW-1), 2^(DW-1)-1].
REQ-018 NEXT SHALL step the center as follows:
- c += 2.
- If c > N-1 and odd_even=1: set c=0, odd_even=0, go to LOAD.
- If c > N-1 and odd_even=0: go to FIN.
- Otherwise go to LOAD.
REQ-019 Every odd center SHALL be written before any even center is read (predict pass fully precedes update pass).
REQ-020 Per center, the cycle count from the first LOAD cycle to WRITE inclusive SHALL be 7+LAT.
REQ-021 FIN SHALL pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-022 rd_en and wr_en SHALL never be high in the same cycle.
REQ-023 Addresses SHALL always lie in [0, N-1].

Reset
REQ-024 While rst_n=0, regardless of clk, the block SHALL hold:
- state IDLE.
- busy=0, done=0, err=0, rd_en=0, wr_en=0.
- rd_addr=0, wr_addr=0, wr_data=0.
- x1..x5=0, odd_even=0.
REQ-025 Reset asserted mid-row SHALL abort without a further write.
REQ-026 After reset release, the block SHALL accept start on the first clk edge.

Verification
REQ-027 N=8, LAT=1, memory 0..7 -> writes in address order 1,3,5,7,0,2,4,6; done exactly 8*8+1 cycles after start; busy high throughout.
REQ-028 N=8, c=7 -> read addresses 5,6,7,6,5; c=0 -> reads 2,1,0,1,2.
REQ-029 Model returns d3=5000 -> wr_data=1023; d3=-5000 -> wr_data=-1024; a2=-3 -> wr_data=-3.
REQ-030 start with row_len=3 -> err pulses once; no rd_en/wr_en; busy stays 0; a following start with N=4 completes normally.
REQ-031 rst_n low during the WAIT of the 3rd center -> all outputs 0 within the same cycle; no wr_en; a new start with N=6 then completes in 6*8+1 cycles.
REQ-032 start pulsed again while busy -> ignored; write sequence and done timing identical to the single-start run.

Source files
------------

// File: rtl/lift_seq.sv
// Row sequencer for a 5-tap lifting step: fetches a mirrored window around each
// center, waits for the external add_mul result, and writes it back (odd pass, then even pass).
module lift_seq #(
  parameter int DW  = 11,
  parameter int RW  = 36,
  parameter int AW  = 9,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] row_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [DW-1:0] x3,
  output logic [DW-1:0] x4,
  output logic [DW-1:0] x5,
  output logic          odd_even,
  input  logic [RW-1:0] d3,
  input  logic [RW-1:0] a2,
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, CAPT = 3'd2, WAIT = 3'd3,
    WRITE = 3'd4, NEXT = 3'd5, FIN = 3'd6
  } state_t;

  localparam int IW = AW + 2;
  localparam logic [7:0] LAT_LAST = (LAT > 0) ? 8'(LAT - 1) : 8'd0;
  localparam logic [RW-1:0] SAT_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [RW-1:0] SAT_MIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t        state_q, state_d;
  logic [AW-1:0] n_q, n_d, c_q, c_d;
  logic          oe_q, oe_d, err_q, err_d, cap_v_q, cap_v_d;
  logic [2:0]    k_q, k_d, cap_k_q, cap_k_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [DW-1:0] x_q [5];
  logic [DW-1:0] x_d [5];

  logic [IW-1:0] n_m1, c_plus2, idx;
  logic          over;
  logic [AW-1:0] ctr, mir;
  logic [RW-1:0] src;
  logic [DW-1:0] sat_v;

  // NEXT issues the first read of the following center, so the center used for
  // addressing there is the already-stepped one.
  always_comb begin
    n_m1    = {2'b00, n_q} - IW'(1);
    c_plus2 = {2'b00, c_q} + IW'(2);
    over    = c_plus2 > n_m1;
    ctr     = c_q;
    if (state_q == NEXT) ctr = over ? '0 : c_plus2[AW-1:0];
    idx = {2'b00, ctr} + {{(IW-3){1'b0}}, k_q} - IW'(2);
    if (idx[IW-1])                       mir = AW'(IW'(0) - idx);
    else if ($signed(idx) > $signed(n_m1)) mir = AW'((n_m1 << 1) - idx);
    else                                 mir = AW'(idx);
  end

  always_comb begin
    src = oe_q ? d3 : a2;
    if ($signed(src) > $signed(SAT_MAX))      sat_v = {1'b0, {(DW-1){1'b1}}};
    else if ($signed(src) < $signed(SAT_MIN)) sat_v = {1'b1, {(DW-1){1'b0}}};
    else                                      sat_v = src[DW-1:0];
  end

  // start is a single-cycle request sampled only in IDLE; anything else drops it.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    c_d     = c_q;
    oe_d    = oe_q;
    k_d     = k_q;
    wcnt_d  = wcnt_q;
    err_d   = 1'b0;
    cap_v_d = 1'b0;
    cap_k_d = k_q;
    x_d     = x_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (cap_v_q && cap_k_q == 3'(i)) x_d[i] = rd_data;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          if (row_len >= AW'(4)) begin
            n_d     = row_len;
            c_d     = AW'(1);
            oe_d    = 1'b1;
            k_d     = 3'd0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        rd_en   = 1'b1;
        cap_v_d = 1'b1;
        if (k_q == 3'd4) state_d = CAPT;
        else             k_d = k_q + 3'd1;
      end
      CAPT: begin
        k_d     = 3'd0;
        wcnt_d  = 8'd0;
        state_d = (LAT == 0) ? WRITE : WAIT;
      end
      WAIT: begin
        if (wcnt_q == LAT_LAST) state_d = WRITE;
        else                    wcnt_d = wcnt_q + 8'd1;
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = (over && !oe_q) ? FIN : NEXT;
      end
      NEXT: begin
        rd_en   = 1'b1;
        cap_v_d = 1'b1;
        cap_k_d = 3'd0;
        k_d     = 3'd1;
        c_d     = ctr;
        if (over) oe_d = 1'b0;
        state_d = LOAD;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      c_q     <= '0;
      oe_q    <= 1'b0;
      k_q     <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      cap_v_q <= 1'b0;
      cap_k_q <= '0;
      for (int i = 0; i < 5; i++) x_q[i] <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      c_q     <= c_d;
      oe_q    <= oe_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      cap_v_q <= cap_v_d;
      cap_k_q <= cap_k_d;
      for (int i = 0; i < 5; i++) x_q[i] <= x_d[i];
    end
  end

  assign busy        = (state_q != IDLE) && (state_q != FIN);
  assign done        = (state_q == FIN);
  assign err         = err_q;
  assign rd_addr     = rd_en ? mir : '0;
  assign wr_addr     = wr_en ? c_q : '0;
  assign wr_data     = wr_en ? sat_v : '0;
  assign x1          = x_q[0];
  assign x2          = x_q[1];
  assign x3          = x_q[2];
  assign x4          = x_q[3];
  assign x5          = x_q[4];
  assign odd_even    = oe_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lift_seq.sv
// Bench for lift_seq: memory and add_mul responders, a reference lifting model
// feeding read/write expectation queues, and directed row scenarios.
module tb_lift_seq;
  localparam int DW = 11, RW = 36, AW = 9, LAT = 1;

  logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [AW-1:0] row_len = '0;
  logic          busy, done, err, rd_en, wr_en, odd_even;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0, wr_data, x1, x2, x3, x4, x5;
  logic [RW-1:0] d3 = '0, a2 = '0;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  lift_seq #(.DW(DW), .RW(RW), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row_len(row_len),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .odd_even(odd_even),
    .d3(d3), .a2(a2), .dbg_state_o(dbg_state)
  );

  int n_checks = 0, n_fail = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    exp_rd_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction
  function automatic int pred(input int w1, input int w2, input int w3);
    return w2 - ((w1 + w3) >>> 1);
  endfunction
  function automatic int upd(input int w1, input int w2, input int w3);
    return w2 + ((w1 + w3 + 2) >>> 2);
  endfunction
  function automatic int mirror(input int i, input int n);
    if (i < 0) return -i;
    if (i > n - 1) return 2 * (n - 1) - i;
    return i;
  endfunction
  function automatic int sat(input int v);
    if (v > (1 << (DW - 1)) - 1) return (1 << (DW - 1)) - 1;
    if (v < -(1 << (DW - 1))) return -(1 << (DW - 1));
    return v;
  endfunction

  // Responders: row memory with one-cycle read latency, add_mul with LAT=1.
  logic [DW-1:0] mem [512];
  int mode = 0, c_d3 = 0, c_a2 = 0;
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    if (mode != 0) begin
      d3 <= RW'(c_d3);
      a2 <= RW'(c_a2);
    end else begin
      d3 <= RW'(pred(sx(x2), sx(x3), sx(x4)));
      a2 <= RW'(upd(sx(x2), sx(x3), sx(x4)));
    end
  end

  always @(negedge clk) begin
    check("rd_wr_overlap", rd_en & wr_en, 0);
    if (rd_en) begin
      check("rd_expected", exp_rd_q.size() > 0, 1);
      if (exp_rd_q.size() > 0) check("rd_addr", rd_addr, exp_rd_q.pop_front());
    end
    if (wr_en) begin
      check("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  task automatic load_and_predict(input int n);
    int m [512];
    for (int i = 0; i < n; i++) mem[i] = DW'(int'($urandom_range(0, 600)) - 300);
    for (int i = 0; i < n; i++) m[i] = sx(mem[i]);
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = (pass == 0) ? 1 : 0; c < n; c += 2) begin
        int w [5];
        int v;
        for (int k = 0; k < 5; k++) begin
          int a;
          a = mirror(c - 2 + k, n);
          exp_rd_q.push_back(AW'(a));
          w[k] = m[a];
        end
        if (mode != 0) v = (pass == 0) ? c_d3 : c_a2;
        else           v = (pass == 0) ? pred(w[1], w[2], w[3]) : upd(w[1], w[2], w[3]);
        m[c] = sat(v);
        exp_q.push_back({AW'(c), DW'(m[c])});
      end
    end
  endtask

  task automatic pulse_start(input int n);
    start   = 1'b1;
    row_len = AW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_row(input int n, input bit extra);
    int cyc, busy_low;
    busy_low = 0;
    load_and_predict(n);
    pulse_start(n);
    cyc = 1;
    while (!done && cyc < 2000) begin
      if (!busy) busy_low++;
      if (extra && (cyc == 10 || cyc == 40)) begin
        start   = 1'b1;
        row_len = AW'((cyc == 10) ? 3 : 5);
      end else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("done_latency", cyc, n * (7 + LAT) + 1);
    check("busy_during_row", busy_low, 0);
    check("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("no_err_in_row", err, 0);
    check("writes_left", exp_q.size(), 0);
    check("reads_left", exp_rd_q.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {busy, done, err, rd_en, wr_en, odd_even, dbg_state}, 0);
    check({tag, "_addr"}, {rd_addr, wr_addr, wr_data}, 0);
    check({tag, "_x"}, {x1, x2, x3, x4, x5}, 0);
  endtask

  initial begin
    int errs, acts, bz;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    run_row(8, 1'b0);

    mode = 1; c_d3 = 5000;  c_a2 = -3;
    run_row(8, 1'b0);
    c_d3 = -5000; c_a2 = 70000;
    run_row(5, 1'b0);
    mode = 0;

    errs = 0; acts = 0; bz = 0;
    pulse_start(3);
    for (int i = 0; i < 4; i++) begin
      errs += int'(err);
      acts += int'(rd_en | wr_en);
      bz   += int'(busy);
      @(posedge clk); #1;
    end
    check("short_row_err", errs, 1);
    check("short_row_mem", acts, 0);
    check("short_row_busy", bz, 0);
    run_row(4, 1'b0);

    load_and_predict(8);
    pulse_start(8);
    repeat (22) begin
      @(posedge clk); #1;
    end
    check("abort_writes_left", exp_q.size(), 6);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("abort");
    check("abort_reads_left", exp_rd_q.size(), 25);
    exp_q.delete();
    exp_rd_q.delete();
    repeat (2) @(negedge clk);
    check_reset_outs("abort_hold");
    rst_n = 1'b1;
    run_row(6, 1'b0);

    run_row(8, 1'b1);
    run_row($urandom_range(4, 20), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
